// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state encoding and control bundle for the RISC
// control FSM, datapath and memory blocks.
package cpu_ctrl_pkg;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_MEM  = 2'b00;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [2:0] NSEL_RN = 3'b001;
   localparam logic [2:0] NSEL_RD = 3'b010;
   localparam logic [2:0] NSEL_RM = 3'b100;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
      S_WIMM, S_GETA, S_GETB, S_ALU, S_ALUZ,
      S_WREG, S_CMP, S_ADDR, S_LADDR, S_MRD,
      S_WMEM, S_GETRD, S_PASSB, S_MWR, S_HALT
   } state_e;

   typedef struct packed {
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       load_ir;
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic       load_addr;
      logic [1:0] mem_cmd;
      logic       halted;
   } ctrl_t;

   // MOV reg and MVN run B through the ALU with A forced to zero
   function automatic logic zero_a(logic [2:0] opc, logic [1:0] op);
      return ((opc == OPC_MOV) && (op == OP_MOVR)) ||
             ((opc == OPC_ALU) && (op == OP_MVN));
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decoder feedback and datapath/memory control strobes of the
// control FSM.
interface cpu_ctrl_fsm_if;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       write;
   logic       loada;
   logic       loadb;
   logic       loadc;
   logic       loads;
   logic       asel;
   logic       bsel;
   logic       load_ir;
   logic       load_pc;
   logic       reset_pc;
   logic       addr_sel;
   logic       load_addr;
   logic [1:0] mem_cmd;
   logic       halted;

   modport master (
      input  opcode, op,
      output nsel, vsel, write, loada, loadb, loadc, loads,
      output asel, bsel, load_ir, load_pc, reset_pc,
      output addr_sel, load_addr, mem_cmd, halted
   );

   modport slave (
      output opcode, op,
      input  nsel, vsel, write, loada, loadb, loadc, loads,
      input  asel, bsel, load_ir, load_pc, reset_pc,
      input  addr_sel, load_addr, mem_cmd, halted
   );
endinterface

// File: rtl/ctrl_out_decode.sv
// Moore output table: maps the current control state to every
// datapath, regfile and memory strobe.
module ctrl_out_decode
   import cpu_ctrl_pkg::*;
(
   input  state_e state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_RST: begin
            ctrl.reset_pc = 1'b1;
            ctrl.load_pc  = 1'b1;
         end
         S_IF1: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_cmd  = MEM_READ;
         end
         S_IF2: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_cmd  = MEM_READ;
            ctrl.load_ir  = 1'b1;
         end
         S_UPC: ctrl.load_pc = 1'b1;
         S_WIMM: begin
            ctrl.nsel  = NSEL_RN;
            ctrl.vsel  = VSEL_IMM;
            ctrl.write = 1'b1;
         end
         S_GETA: begin
            ctrl.nsel  = NSEL_RN;
            ctrl.loada = 1'b1;
         end
         S_GETB: begin
            ctrl.nsel  = NSEL_RM;
            ctrl.loadb = 1'b1;
         end
         S_ALU: ctrl.loadc = 1'b1;
         S_ALUZ: begin
            ctrl.asel  = 1'b1;
            ctrl.loadc = 1'b1;
         end
         S_WREG: begin
            ctrl.nsel  = NSEL_RD;
            ctrl.vsel  = VSEL_C;
            ctrl.write = 1'b1;
         end
         S_CMP: ctrl.loads = 1'b1;
         S_ADDR: begin
            ctrl.bsel  = 1'b1;
            ctrl.loadc = 1'b1;
         end
         S_LADDR: ctrl.load_addr = 1'b1;
         S_MRD: ctrl.mem_cmd = MEM_READ;
         S_WMEM: begin
            ctrl.mem_cmd = MEM_READ;
            ctrl.nsel    = NSEL_RD;
            ctrl.vsel    = VSEL_MDATA;
            ctrl.write   = 1'b1;
         end
         S_GETRD: begin
            ctrl.nsel  = NSEL_RD;
            ctrl.loadb = 1'b1;
         end
         S_PASSB: begin
            ctrl.asel  = 1'b1;
            ctrl.loadc = 1'b1;
         end
         S_MWR: ctrl.mem_cmd = MEM_WRITE;
         S_HALT: ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM: fetch, PC update, decode and execute
// sequencing for the RISC machine.
module cpu_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W      = 5,
   parameter bit          ILLEGAL_HALT = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   cpu_ctrl_fsm_if.master bus
);

   if (STATE_W < $bits(state_e)) begin : g_bad_w
      $error("STATE_W too narrow for the state encoding");
   end

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl;

   logic is_movi, is_movr, is_add, is_and, is_cmp;
   logic is_mvn, is_ldr, is_str, is_halt, is_mem, is_za;

   assign is_movi = (bus.opcode == OPC_MOV) && (bus.op == OP_MOVI);
   assign is_movr = (bus.opcode == OPC_MOV) && (bus.op == OP_MOVR);
   assign is_add  = (bus.opcode == OPC_ALU) && (bus.op == OP_ADD);
   assign is_and  = (bus.opcode == OPC_ALU) && (bus.op == OP_AND);
   assign is_cmp  = (bus.opcode == OPC_ALU) && (bus.op == OP_CMP);
   assign is_mvn  = (bus.opcode == OPC_ALU) && (bus.op == OP_MVN);
   assign is_ldr  = (bus.opcode == OPC_LDR) && (bus.op == OP_MEM);
   assign is_str  = (bus.opcode == OPC_STR) && (bus.op == OP_MEM);
   assign is_halt = (bus.opcode == OPC_HALT);
   assign is_mem  = is_ldr | is_str;
   assign is_za   = zero_a(bus.opcode, bus.op);

   // opcode/op are only sampled after S_IF2, when the IR is stable
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST: state_d = S_IF1;
         S_IF1: state_d = S_IF2;
         S_IF2: state_d = S_UPC;
         S_UPC: state_d = S_DEC;
         S_DEC: begin
            unique case (1'b1)
               is_movi: state_d = S_WIMM;
               is_movr, is_mvn: state_d = S_GETB;
               is_add, is_and, is_cmp, is_ldr, is_str:
                  state_d = S_GETA;
               is_halt: state_d = S_HALT;
               default: state_d = ILLEGAL_HALT ? S_HALT : S_IF1;
            endcase
         end
         S_GETA: state_d = is_mem ? S_ADDR : S_GETB;
         S_GETB: state_d = is_cmp ? S_CMP :
                           (is_za ? S_ALUZ : S_ALU);
         S_ALU, S_ALUZ: state_d = S_WREG;
         S_ADDR: state_d = S_LADDR;
         S_LADDR: state_d = is_str ? S_GETRD : S_MRD;
         S_MRD: state_d = S_WMEM;
         S_GETRD: state_d = S_PASSB;
         S_PASSB: state_d = S_MWR;
         S_WIMM, S_WREG, S_CMP, S_WMEM, S_MWR: state_d = S_IF1;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RST;
      else       state_q <= state_d;
   end

   ctrl_out_decode u_dec (
      .state (state_q),
      .ctrl  (ctrl)
   );

   assign bus.nsel      = ctrl.nsel;
   assign bus.vsel      = ctrl.vsel;
   assign bus.write     = ctrl.write;
   assign bus.loada     = ctrl.loada;
   assign bus.loadb     = ctrl.loadb;
   assign bus.loadc     = ctrl.loadc;
   assign bus.loads     = ctrl.loads;
   assign bus.asel      = ctrl.asel;
   assign bus.bsel      = ctrl.bsel;
   assign bus.load_ir   = ctrl.load_ir;
   assign bus.load_pc   = ctrl.load_pc;
   assign bus.reset_pc  = ctrl.reset_pc;
   assign bus.addr_sel  = ctrl.addr_sel;
   assign bus.load_addr = ctrl.load_addr;
   assign bus.mem_cmd   = ctrl.mem_cmd;
   assign bus.halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: per-cycle expected output
// vectors are queued by the stimulus and checked by a monitor.
module tb_cpu_ctrl_fsm;

   logic clk;
   logic reset;

   cpu_ctrl_fsm_if bus ();

   cpu_ctrl_fsm #(
      .STATE_W      (5),
      .ILLEGAL_HALT (1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {nsel, vsel, w la lb lc ls as bs ir lpc rpc asl ladr, mem, halted}
   function automatic logic [19:0] cv(logic [2:0] n, logic [1:0] v,
                                      logic [11:0] s, logic [1:0] m,
                                      logic h);
      return {n, v, s, m, h};
   endfunction

   localparam logic [19:0] E_RST   = cv(3'b000, 2'b00, 12'b0000_0000_1100, 2'b00, 1'b0);
   localparam logic [19:0] E_IF1   = cv(3'b000, 2'b00, 12'b0000_0000_0010, 2'b01, 1'b0);
   localparam logic [19:0] E_IF2   = cv(3'b000, 2'b00, 12'b0000_0001_0010, 2'b01, 1'b0);
   localparam logic [19:0] E_UPC   = cv(3'b000, 2'b00, 12'b0000_0000_1000, 2'b00, 1'b0);
   localparam logic [19:0] E_DEC   = cv(3'b000, 2'b00, 12'b0000_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_WIMM  = cv(3'b001, 2'b10, 12'b1000_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_GETA  = cv(3'b001, 2'b00, 12'b0100_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_GETB  = cv(3'b100, 2'b00, 12'b0010_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_ALU   = cv(3'b000, 2'b00, 12'b0001_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_ALUZ  = cv(3'b000, 2'b00, 12'b0001_0100_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_WREG  = cv(3'b010, 2'b00, 12'b1000_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_CMP   = cv(3'b000, 2'b00, 12'b0000_1000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_ADDR  = cv(3'b000, 2'b00, 12'b0001_0010_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_LADDR = cv(3'b000, 2'b00, 12'b0000_0000_0001, 2'b00, 1'b0);
   localparam logic [19:0] E_MRD   = cv(3'b000, 2'b00, 12'b0000_0000_0000, 2'b01, 1'b0);
   localparam logic [19:0] E_WMEM  = cv(3'b010, 2'b11, 12'b1000_0000_0000, 2'b01, 1'b0);
   localparam logic [19:0] E_GETRD = cv(3'b010, 2'b00, 12'b0010_0000_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_PASSB = cv(3'b000, 2'b00, 12'b0001_0100_0000, 2'b00, 1'b0);
   localparam logic [19:0] E_MWR   = cv(3'b000, 2'b00, 12'b0000_0000_0000, 2'b10, 1'b0);
   localparam logic [19:0] E_HALT  = cv(3'b000, 2'b00, 12'b0000_0000_0000, 2'b00, 1'b1);

   typedef struct {
      int          step;
      logic [19:0] v;
   } exp_t;

   exp_t        exp_q[$];
   logic [19:0] stage[$];
   string       cur;
   int          checks;
   int          failures;
   logic [19:0] act;

   assign act = {bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb,
                 bus.loadc, bus.loads, bus.asel, bus.bsel, bus.load_ir,
                 bus.load_pc, bus.reset_pc, bus.addr_sel, bus.load_addr,
                 bus.mem_cmd, bus.halted};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL %s step %0d: outputs=%05h expected=%05h",
                     cur, e.step, act, e.v);
         end
      end
   end

   task automatic prefix();
      stage.push_back(E_RST);
      stage.push_back(E_RST);
      stage.push_back(E_IF1);
      stage.push_back(E_IF2);
      stage.push_back(E_UPC);
      stage.push_back(E_DEC);
   endtask

   // reset for two cycles, then run; abort_at>0 re-asserts reset for
   // one cycle that many cycles after release
   task automatic run(string name, logic [2:0] opc, logic [1:0] o,
                      int abort_at);
      cur = name;
      bus.opcode = opc;
      bus.op = o;
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < stage.size(); i++)
         exp_q.push_back('{i, stage[i]});
      stage.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      if (abort_at > 0) begin
         repeat (abort_at) @(posedge clk);
         #1 reset = 1'b1;
         @(posedge clk);
         #1 reset = 1'b0;
      end
      for (int i = 0; i < 60 && exp_q.size() > 0; i++)
         @(posedge clk);
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL %s drain: pending=%0d required=0",
                  name, exp_q.size());
         exp_q.delete();
      end
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus.opcode = 3'b000;
      bus.op = 2'b00;
      @(posedge clk);
      #1;

      prefix(); stage.push_back(E_WIMM); stage.push_back(E_IF1);
      run("mov_imm", 3'b110, 2'b10, 0);

      prefix(); stage.push_back(E_GETA); stage.push_back(E_GETB);
      stage.push_back(E_ALU); stage.push_back(E_WREG);
      stage.push_back(E_IF1);
      run("add", 3'b101, 2'b00, 0);

      prefix(); stage.push_back(E_GETA); stage.push_back(E_GETB);
      stage.push_back(E_ALU); stage.push_back(E_WREG);
      stage.push_back(E_IF1);
      run("and", 3'b101, 2'b10, 0);

      prefix(); stage.push_back(E_GETA); stage.push_back(E_GETB);
      stage.push_back(E_CMP); stage.push_back(E_IF1);
      run("cmp", 3'b101, 2'b01, 0);

      prefix(); stage.push_back(E_GETB); stage.push_back(E_ALUZ);
      stage.push_back(E_WREG); stage.push_back(E_IF1);
      run("mov_reg", 3'b110, 2'b00, 0);

      prefix(); stage.push_back(E_GETB); stage.push_back(E_ALUZ);
      stage.push_back(E_WREG); stage.push_back(E_IF1);
      run("mvn", 3'b101, 2'b11, 0);

      prefix(); stage.push_back(E_GETA); stage.push_back(E_ADDR);
      stage.push_back(E_LADDR); stage.push_back(E_MRD);
      stage.push_back(E_WMEM); stage.push_back(E_IF1);
      run("ldr", 3'b011, 2'b00, 0);

      prefix(); stage.push_back(E_GETA); stage.push_back(E_ADDR);
      stage.push_back(E_LADDR); stage.push_back(E_GETRD);
      stage.push_back(E_PASSB); stage.push_back(E_MWR);
      stage.push_back(E_IF1);
      run("str", 3'b100, 2'b00, 0);

      prefix(); stage.push_back(E_IF1); stage.push_back(E_IF2);
      run("illegal_000", 3'b000, 2'b00, 0);

      prefix(); stage.push_back(E_IF1); stage.push_back(E_IF2);
      run("illegal_ldr_op01", 3'b011, 2'b01, 0);

      prefix();
      for (int i = 0; i < 22; i++) stage.push_back(E_HALT);
      run("halt", 3'b111, 2'b01, 0);

      // entered straight from S_HALT, so the first two checks also
      // cover reset out of halt
      prefix(); stage.push_back(E_GETA); stage.push_back(E_ADDR);
      stage.push_back(E_LADDR); stage.push_back(E_MRD);
      stage.push_back(E_RST); stage.push_back(E_IF1);
      stage.push_back(E_IF2);
      run("ldr_abort", 3'b011, 2'b00, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
